// File: rtl/pe_bus_pkg.sv
// Shared definitions for the PE-to-CGRA bus bridge: op codes, FSM states and
// the packing width of one queued PE command.
package pe_bus_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_MEM_RD = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM_WR = 2'b01;
    localparam logic [OP_W-1:0] OP_REG_RD = 2'b10;
    localparam logic [OP_W-1:0] OP_REG_WR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_RESP
    } bridgeState_e;

    // Entry layout: {op, addr, data, pc, rs1, rs2, rd}
    function automatic int entryWidth(input int addrW, input int dataW, input int regW);
        return OP_W + 2 * addrW + dataW + 3 * regW;
    endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous FIFO holding PE bus commands. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate flag.
module bus_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign count  = wrPtr - rdPtr;
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full)
                wrPtr <= wrPtr + 1'b1;
            if (pop && !empty)
                rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset; the bridge only exposes the head while issuing.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/pe_bus_bridge.sv
// Queued bridge between one RISC-V PE and the shared CGRA bus: buffers commands,
// arbitrates for the bus, issues one command at a time and returns tagged responses.
module pe_bus_bridge
    import pe_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       pe_req_valid,
    output logic                       pe_req_ready,
    input  logic [OP_W-1:0]            pe_req_op,
    input  logic [ADDR_W-1:0]          pe_req_addr,
    input  logic [DATA_W-1:0]          pe_req_data,
    input  logic [ADDR_W-1:0]          pe_req_pc,
    input  logic [REG_W-1:0]           pe_req_rs1,
    input  logic [REG_W-1:0]           pe_req_rs2,
    input  logic [REG_W-1:0]           pe_req_rd,

    output logic                       pe_rsp_valid,
    output logic [OP_W-1:0]            pe_rsp_op,
    output logic [DATA_W-1:0]          pe_rsp_data_a,
    output logic [DATA_W-1:0]          pe_rsp_data_b,
    output logic                       pe_rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] pe_pending,

    input  logic                       exec_done_pe,
    output logic                       exec_done_bus,

    output logic                       bus_request,
    input  logic                       grant,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [ADDR_W-1:0]          bus_pc,
    output logic [DATA_W-1:0]          bus_wdata,
    output logic [REG_W-1:0]           bus_rs1,
    output logic [REG_W-1:0]           bus_rs2,
    output logic [REG_W-1:0]           bus_rd,
    output logic                       bus_mem_read,
    output logic                       bus_mem_write,
    output logic                       bus_rd_write,
    output logic                       bus_read_en,
    output logic                       bus_reg_select,
    input  logic                       bus_mem_ack,
    input  logic                       bus_data_ready,
    input  logic [DATA_W-1:0]          bus_mem_data,
    input  logic [DATA_W-1:0]          bus_amux,
    input  logic [DATA_W-1:0]          bus_bmux
);

    localparam int ENTRY_W = entryWidth(ADDR_W, DATA_W, REG_W);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    bridgeState_e       state;
    logic [ENTRY_W-1:0] pushEntry;
    logic [ENTRY_W-1:0] head;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [TO_W-1:0]    toCnt;

    logic [OP_W-1:0]    hOp;
    logic [ADDR_W-1:0]  hAddr;
    logic [DATA_W-1:0]  hData;
    logic [ADDR_W-1:0]  hPc;
    logic [REG_W-1:0]   hRs1;
    logic [REG_W-1:0]   hRs2;
    logic [REG_W-1:0]   hRd;

    logic               issuing;
    logic               done;
    logic               timedOut;

    assign pushEntry = {pe_req_op, pe_req_addr, pe_req_data, pe_req_pc,
                        pe_req_rs1, pe_req_rs2, pe_req_rd};
    assign {hOp, hAddr, hData, hPc, hRs1, hRs2, hRd} = head;

    assign push = pe_req_valid && !fifoFull;
    assign pop  = (state == ST_RESP);

    bus_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wrData (pushEntry),
        .pop    (pop),
        .rdData (head),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    assign issuing = (state == ST_ISSUE);

    always_comb begin
        done = 1'b0;
        if (issuing) begin
            case (hOp)
                OP_MEM_RD, OP_MEM_WR: done = bus_mem_ack;
                OP_REG_RD:            done = bus_data_ready;
                default:              done = 1'b1;
            endcase
        end
    end

    assign timedOut = issuing && (TIMEOUT != 0) && (toCnt == TO_W'(TIMEOUT - 1));

    // Completion is tested before timeout so a late ack on the last cycle still succeeds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            toCnt         <= '0;
            pe_rsp_op     <= '0;
            pe_rsp_data_a <= '0;
            pe_rsp_data_b <= '0;
            pe_rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifoEmpty)
                        state <= ST_REQ;
                end
                ST_REQ: begin
                    if (grant) begin
                        state <= ST_ISSUE;
                        toCnt <= '0;
                    end
                end
                ST_ISSUE: begin
                    toCnt <= toCnt + 1'b1;
                    if (done) begin
                        state         <= ST_RESP;
                        pe_rsp_op     <= hOp;
                        pe_rsp_err    <= 1'b0;
                        pe_rsp_data_a <= (hOp == OP_MEM_RD) ? bus_mem_data :
                                         (hOp == OP_REG_RD) ? bus_amux : '0;
                        pe_rsp_data_b <= (hOp == OP_REG_RD) ? bus_bmux : '0;
                    end else if (timedOut) begin
                        state         <= ST_RESP;
                        pe_rsp_op     <= hOp;
                        pe_rsp_err    <= 1'b1;
                        pe_rsp_data_a <= '0;
                        pe_rsp_data_b <= '0;
                    end
                end
                ST_RESP: begin
                    state <= (count > CNT_W'(1) || push) ? ST_REQ : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            exec_done_bus <= 1'b0;
        else
            exec_done_bus <= exec_done_pe;
    end

    assign pe_req_ready = !fifoFull;
    assign pe_pending   = count;
    assign pe_rsp_valid = (state == ST_RESP);
    assign bus_request  = (state == ST_REQ) || issuing;

    assign bus_addr  = issuing ? hAddr : '0;
    assign bus_pc    = issuing ? hPc   : '0;
    assign bus_wdata = issuing ? hData : '0;
    assign bus_rs1   = issuing ? hRs1  : '0;
    assign bus_rs2   = issuing ? hRs2  : '0;
    assign bus_rd    = issuing ? hRd   : '0;

    assign bus_mem_read   = issuing && (hOp == OP_MEM_RD);
    assign bus_mem_write  = issuing && (hOp == OP_MEM_WR);
    assign bus_read_en    = issuing && (hOp == OP_REG_RD);
    assign bus_reg_select = issuing && (hOp == OP_REG_RD);
    assign bus_rd_write   = issuing && (hOp == OP_REG_WR);

endmodule

// File: tb/tb_pe_bus_bridge.sv
// Scoreboard bench for pe_bus_bridge: expected responses are queued on enqueue and
// compared as the bridge emits them, with a bus responder that acks after a set delay.
module tb_pe_bus_bridge;
    import pe_bus_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int REG_W   = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [31:0] MASK = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pe_req_valid = 1'b0;
    logic pe_req_ready;
    logic [1:0] pe_req_op = '0;
    logic [ADDR_W-1:0] pe_req_addr = '0;
    logic [DATA_W-1:0] pe_req_data = '0;
    logic [ADDR_W-1:0] pe_req_pc = '0;
    logic [REG_W-1:0] pe_req_rs1 = '0, pe_req_rs2 = '0, pe_req_rd = '0;
    logic pe_rsp_valid;
    logic [1:0] pe_rsp_op;
    logic [DATA_W-1:0] pe_rsp_data_a, pe_rsp_data_b;
    logic pe_rsp_err;
    logic [CNT_W-1:0] pe_pending;
    logic exec_done_pe = 1'b0;
    logic exec_done_bus;
    logic bus_request;
    logic grant = 1'b0;
    logic [ADDR_W-1:0] bus_addr, bus_pc;
    logic [DATA_W-1:0] bus_wdata;
    logic [REG_W-1:0] bus_rs1, bus_rs2, bus_rd;
    logic bus_mem_read, bus_mem_write, bus_rd_write, bus_read_en, bus_reg_select;
    logic bus_mem_ack = 1'b0;
    logic bus_data_ready = 1'b0;
    logic [DATA_W-1:0] bus_mem_data = '0, bus_amux = '0, bus_bmux = '0;

    pe_bus_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .pe_req_valid(pe_req_valid), .pe_req_ready(pe_req_ready), .pe_req_op(pe_req_op),
        .pe_req_addr(pe_req_addr), .pe_req_data(pe_req_data), .pe_req_pc(pe_req_pc),
        .pe_req_rs1(pe_req_rs1), .pe_req_rs2(pe_req_rs2), .pe_req_rd(pe_req_rd),
        .pe_rsp_valid(pe_rsp_valid), .pe_rsp_op(pe_rsp_op), .pe_rsp_data_a(pe_rsp_data_a),
        .pe_rsp_data_b(pe_rsp_data_b), .pe_rsp_err(pe_rsp_err), .pe_pending(pe_pending),
        .exec_done_pe(exec_done_pe), .exec_done_bus(exec_done_bus),
        .bus_request(bus_request), .grant(grant), .bus_addr(bus_addr), .bus_pc(bus_pc),
        .bus_wdata(bus_wdata), .bus_rs1(bus_rs1), .bus_rs2(bus_rs2), .bus_rd(bus_rd),
        .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write), .bus_rd_write(bus_rd_write),
        .bus_read_en(bus_read_en), .bus_reg_select(bus_reg_select), .bus_mem_ack(bus_mem_ack),
        .bus_data_ready(bus_data_ready), .bus_mem_data(bus_mem_data), .bus_amux(bus_amux),
        .bus_bmux(bus_bmux)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    int nChk = 0, nErr = 0;
    int cyc = 0, acceptCyc = 0, lastRspCyc = 0, rspCount = 0;
    int ackDelay = 1, issueCyc = 0;
    bit noAck = 1'b0, addrData = 1'b0, gapMon = 1'b0;
    int nMemRd = 0, nMemWr = 0, nRdEn = 0, nRdWr = 0, lowCyc = 0, lowNoRsp = 0;
    logic [31:0] lastAddr = '0, lastWdata = '0, lastPc = '0;
    logic [4:0] lastRs1 = '0, lastRs2 = '0, lastRd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus responder, strobe bookkeeping and response scoreboard.
    initial forever begin
        logic anyStrobe;
        rsp_t e;
        @(negedge clk);
        anyStrobe = bus_mem_read | bus_mem_write | bus_read_en | bus_rd_write;
        issueCyc = anyStrobe ? issueCyc + 1 : 0;
        if (bus_mem_read)  nMemRd++;
        if (bus_mem_write) nMemWr++;
        if (bus_rd_write)  nRdWr++;
        if (bus_read_en) begin
            nRdEn++;
            chk("reg_select", bus_reg_select, 1);
        end
        if (anyStrobe) begin
            lastAddr = bus_addr; lastWdata = bus_wdata; lastPc = bus_pc;
            lastRs1 = bus_rs1; lastRs2 = bus_rs2; lastRd = bus_rd;
        end
        bus_mem_ack    = !noAck && issueCyc == ackDelay && (bus_mem_read | bus_mem_write);
        bus_data_ready = !noAck && issueCyc == ackDelay && bus_read_en;
        if (addrData) bus_mem_data = bus_addr ^ MASK;
        if (gapMon && expQ.size() > 0 && !bus_request) begin
            lowCyc++;
            if (!pe_rsp_valid) lowNoRsp++;
        end
        if (pe_rsp_valid) begin
            rspCount++;
            lastRspCyc = cyc;
            if (expQ.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = expQ.pop_front();
                chk("rsp_op",  pe_rsp_op,     e.op);
                chk("rsp_a",   pe_rsp_data_a, e.a);
                chk("rsp_b",   pe_rsp_data_b, e.b);
                chk("rsp_err", pe_rsp_err,    e.err);
            end
        end
    end

    task automatic sendCmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] ea, input logic [31:0] eb,
                           input logic ee);
        int n = 0;
        rsp_t r;
        @(negedge clk);
        while (!pe_req_ready && n < 200) begin @(negedge clk); n++; end
        if (!pe_req_ready) begin
            chk("req_ready_wait", pe_req_ready, 1);
            return;
        end
        pe_req_op = op; pe_req_addr = addr; pe_req_data = data; pe_req_pc = pc;
        pe_req_rs1 = rs1; pe_req_rs2 = rs2; pe_req_rd = rd; pe_req_valid = 1'b1;
        r.op = op; r.a = ea; r.b = eb; r.err = ee;
        expQ.push_back(r);
        @(negedge clk);
        acceptCyc = cyc;
        pe_req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (expQ.size() != 0) chk("drain_wait", expQ.size(), 0);
        @(negedge clk);
    endtask

    task automatic clrCounts();
        nMemRd = 0; nMemWr = 0; nRdEn = 0; nRdWr = 0;
    endtask

    initial begin
        int rc;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready",   pe_req_ready, 1);
        chk("rst_pending", pe_pending, 0);
        chk("rst_busreq",  bus_request, 0);
        chk("rst_rspv",    pe_rsp_valid, 0);
        chk("rst_strobes", {bus_mem_read, bus_mem_write, bus_rd_write, bus_read_en, bus_reg_select}, 0);
        chk("rst_exec",    exec_done_bus, 0);
        chk("rst_addr",    bus_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        exec_done_pe = 1'b1;
        #1 chk("exec_lag0", exec_done_bus, 0);
        @(negedge clk);
        chk("exec_lag1", exec_done_bus, 1);
        exec_done_pe = 1'b0;
        @(negedge clk);
        chk("exec_lag2", exec_done_bus, 0);

        // Minimum-latency memory write
        grant = 1'b1; ackDelay = 1; clrCounts();
        sendCmd(OP_MEM_WR, 32'hAABBCCDD, 32'h12345678, 32'h0000_0100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("t1_pending", pe_pending, 1);
        waitDrain();
        chk("t1_latency", lastRspCyc - acceptCyc, 3);
        chk("t1_wr_cycles", nMemWr, 1);
        chk("t1_addr", lastAddr, 32'hAABBCCDD);
        chk("t1_wdata", lastWdata, 32'h12345678);
        chk("t1_pc", lastPc, 32'h0000_0100);
        chk("t1_pending_end", pe_pending, 0);

        // Memory read acked on the third ISSUE cycle
        clrCounts(); ackDelay = 3; bus_mem_data = 32'h87654321;
        sendCmd(OP_MEM_RD, 32'h11223344, 32'h0, 32'h0000_0104, 5'd0, 5'd0, 5'd0, 32'h87654321, 32'h0, 1'b0);
        waitDrain();
        chk("t2_rd_cycles", nMemRd, 3);
        chk("t2_addr", lastAddr, 32'h11223344);

        // Register read then register write
        clrCounts(); ackDelay = 2; bus_amux = 32'hABCD1234; bus_bmux = 32'hDCBA4321;
        sendCmd(OP_REG_RD, 32'h0, 32'h0, 32'h0000_0108, 5'd1, 5'd2, 5'd0, 32'hABCD1234, 32'hDCBA4321, 1'b0);
        waitDrain();
        chk("t3_rden_cycles", nRdEn, 2);
        chk("t3_rs1", lastRs1, 1);
        chk("t3_rs2", lastRs2, 2);
        clrCounts();
        sendCmd(OP_REG_WR, 32'h0, 32'hFACECAFE, 32'h0000_010C, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 1'b0);
        waitDrain();
        chk("t3_rdwr_cycles", nRdWr, 1);
        chk("t3_rd", lastRd, 10);
        chk("t3_wdata", lastWdata, 32'hFACECAFE);

        // Fill the queue with grant withheld, then drain in order
        grant = 1'b0; ackDelay = 1; addrData = 1'b1; clrCounts();
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] a;
            a = 32'h1000_0000 + 32'(i) * 32'h10;
            sendCmd(OP_MEM_RD, a, 32'h0, 32'h200 + 32'(i), 5'd0, 5'd0, 5'd0, a ^ MASK, 32'h0, 1'b0);
        end
        chk("t4_full_ready", pe_req_ready, 0);
        chk("t4_full_pending", pe_pending, DEPTH);
        pe_req_op = OP_MEM_WR; pe_req_addr = 32'hDEAD0000; pe_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_fifth_pending", pe_pending, DEPTH);
        chk("t4_fifth_ready", pe_req_ready, 0);
        chk("t4_busreq_wait", bus_request, 1);
        pe_req_valid = 1'b0;
        lowCyc = 0; lowNoRsp = 0; gapMon = 1'b1;
        grant = 1'b1;
        waitDrain();
        gapMon = 1'b0;
        chk("t4_rd_cycles", nMemRd, DEPTH);
        chk("t4_gap_lows", lowCyc, DEPTH);
        chk("t4_gap_extra", lowNoRsp, 0);
        addrData = 1'b0;

        // Timeout without ack, then ack on the final allowed cycle
        clrCounts(); noAck = 1'b1;
        sendCmd(OP_MEM_RD, 32'h0000_0055, 32'h0, 32'h300, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
        waitDrain();
        chk("t5_to_cycles", nMemRd, TIMEOUT);
        clrCounts(); noAck = 1'b0; ackDelay = TIMEOUT; bus_mem_data = 32'hCAFEF00D;
        sendCmd(OP_MEM_RD, 32'h0000_0066, 32'h0, 32'h304, 5'd0, 5'd0, 5'd0, 32'hCAFEF00D, 32'h0, 1'b0);
        waitDrain();
        chk("t5_late_cycles", nMemRd, TIMEOUT);

        // Reset while a command is on the bus
        noAck = 1'b1;
        sendCmd(OP_MEM_RD, 32'h0000_0077, 32'h0, 32'h308, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
        n = 0;
        while (!bus_mem_read && n < 20) begin @(negedge clk); n++; end
        chk("t6_reached_issue", bus_mem_read, 1);
        reset = 1'b0;
        #1;
        chk("t6_strobe_drop", bus_mem_read, 0);
        chk("t6_busreq_drop", bus_request, 0);
        chk("t6_pending", pe_pending, 0);
        chk("t6_ready", pe_req_ready, 1);
        expQ.delete();
        rc = rspCount;
        @(negedge clk);
        reset = 1'b1; noAck = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_rsp", rspCount, rc);
        chk("t6_busreq_idle", bus_request, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
        $finish;
    end

endmodule
